i_execute: RTL and testbench

//  - Execute stage of the 5-stage LEGv8 pipeline. Sits directly upstream of the memory stage.
//  - Performs ALU operand select, ALU control decode, ALU op and branch-target add.
//  - Holds the EX/MEM pipeline register that drives the memory stage's inputs
//    (control bits, zero, alu_result, read_data2, branch-target pc).
//  - Supports stall and flush. Optional iterative multiplier.

---
 rtl/i_execute_pkg.sv | 47 ++++
 rtl/i_execute_alu_ctrl.sv | 27 ++
 rtl/i_execute.sv | 180 ++++++++++++++++++
 tb/tb_i_execute.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i_execute_pkg.sv
// i_execute_pkg: shared definitions for the LEGv8 execute stage.
//   WORD         default datapath width
//   OP_*         11-bit R-type opcodes decoded when alu_op = ALU_OP_RTYPE
//   ALU_OP_*     alu_op encodings coming from the main control unit
//   alu_fn_e     ALU function chosen by the ALU control decoder
//   mul_state_e  iterative multiplier FSM states (used only with IE_MUL_EN)
//   ex_ctrl_t    control bits carried through the EX/MEM register
package i_execute_pkg;

    localparam int WORD = 64;

    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;
    localparam logic [10:0] OP_MUL = 11'b10011011000;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_PASSB = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
    localparam logic [1:0] ALU_OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        FN_ADD,
        FN_SUB,
        FN_AND,
        FN_ORR,
        FN_PASSB,
        FN_MUL,
        FN_ZERO
    } alu_fn_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } mul_state_e;

    typedef struct packed {
        logic uncondbranch;
        logic branch;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ex_ctrl_t;

endpackage

// File: rtl/i_execute_alu_ctrl.sv
// i_execute_alu_ctrl: combinational ALU control decode.
//   alu_op_i  in  2    main-control ALU class (add / pass-B / R-type / reserved)
//   opcode_i  in  OPW  instr[31:21], consulted only for R-type
//   alu_fn_o  out      ALU function; unknown R-type opcodes map to FN_ZERO
module i_execute_alu_ctrl
    import i_execute_pkg::*;
#(
    parameter int OPW = 11
) (
    input  logic [1:0]     alu_op_i,
    input  logic [OPW-1:0] opcode_i,
    output alu_fn_e        alu_fn_o
);

    alu_fn_e rtype_fn;

    assign rtype_fn = (opcode_i == OPW'(OP_ADD)) ? FN_ADD :
                      (opcode_i == OPW'(OP_SUB)) ? FN_SUB :
                      (opcode_i == OPW'(OP_AND)) ? FN_AND :
                      (opcode_i == OPW'(OP_ORR)) ? FN_ORR :
                      (opcode_i == OPW'(OP_MUL)) ? FN_MUL : FN_ZERO;

    // The reserved encoding falls back to add.
    assign alu_fn_o = (alu_op_i == ALU_OP_PASSB) ? FN_PASSB :
                      (alu_op_i == ALU_OP_RTYPE) ? rtype_fn : FN_ADD;

endmodule

// File: rtl/i_execute.sv
// i_execute: LEGv8 execute stage with the EX/MEM pipeline register.
//   ie_clk, ie_rst_n                 clock, asynchronous active-low reset
//   flush                            squash the instruction in EX (load a bubble)
//   pc_in, read_data1, read_data2_in, sign_ext_imm, opcode, alu_op, alu_src  EX operands/decode
//   uncondbranch_in .. mem_to_reg_in EX control bits
//   stall                            upstream must hold its inputs next cycle
//   uncondbranch .. mem_to_reg, zero, alu_result, read_data2, pc_out  registered EX/MEM outputs
// Optional feature: define IE_MUL_EN for the iterative shift-add MUL; without it
// MUL decodes to 0 and stall is tied low.
module i_execute
    import i_execute_pkg::*;
#(
    parameter int DW  = WORD,
    parameter int OPW = 11
`ifdef IE_MUL_EN
    ,
    parameter int MUL_STEPS = DW
`endif
) (
    input  logic           ie_clk,
    input  logic           ie_rst_n,
    input  logic           flush,
    input  logic [DW-1:0]  pc_in,
    input  logic [DW-1:0]  read_data1,
    input  logic [DW-1:0]  read_data2_in,
    input  logic [DW-1:0]  sign_ext_imm,
    input  logic [OPW-1:0] opcode,
    input  logic [1:0]     alu_op,
    input  logic           alu_src,
    input  logic           uncondbranch_in,
    input  logic           branch_in,
    input  logic           mem_read_in,
    input  logic           mem_write_in,
    input  logic           mem_to_reg_in,
    output logic           stall,
    output logic           uncondbranch,
    output logic           branch,
    output logic           mem_read,
    output logic           mem_write,
    output logic           mem_to_reg,
    output logic           zero,
    output logic [DW-1:0]  alu_result,
    output logic [DW-1:0]  read_data2,
    output logic [DW-1:0]  pc_out
);

    alu_fn_e       alu_fn;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_res;
    logic [DW-1:0] res_d;
    logic [DW-1:0] pc_tgt;
    logic          stall_int;
    logic          bubble;
    ex_ctrl_t      ctrl_in;
    ex_ctrl_t      ctrl_d;
    ex_ctrl_t      ctrl_q;
    logic          zero_q;
    logic [DW-1:0] alu_result_q;
    logic [DW-1:0] read_data2_q;
    logic [DW-1:0] pc_out_q;

    i_execute_alu_ctrl #(.OPW(OPW)) u_alu_ctrl (
        .alu_op_i (alu_op),
        .opcode_i (opcode),
        .alu_fn_o (alu_fn)
    );

    always_comb begin
        alu_b = alu_src ? sign_ext_imm : read_data2_in;
        case (alu_fn)
            FN_ADD:   alu_res = read_data1 + alu_b;
            FN_SUB:   alu_res = read_data1 - alu_b;
            FN_AND:   alu_res = read_data1 & alu_b;
            FN_ORR:   alu_res = read_data1 | alu_b;
            FN_PASSB: alu_res = alu_b;
            default:  alu_res = '0;
        endcase
    end

    // Branch offsets are in words, so scale by 4 before adding.
    assign pc_tgt = pc_in + (sign_ext_imm << 2);

`ifdef IE_MUL_EN
    localparam int            CW   = $clog2(MUL_STEPS + 1);
    localparam logic [CW-1:0] LAST = CW'(MUL_STEPS - 1);

    mul_state_e    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] mcand_q, mcand_d;
    logic [DW-1:0] mplier_q, mplier_d;
    logic [DW-1:0] prod_q, prod_d;
    logic          is_mul;
    logic          mul_done;

    assign is_mul = alu_fn == FN_MUL;

    always_ff @(posedge ie_clk or negedge ie_rst_n) begin
        if (!ie_rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

    // Flush aborts the multiply from any state; the unused encoding recovers to IDLE.
    always_comb begin
        state_d = flush                ? S_IDLE :
                  (state_q == S_IDLE) ? (is_mul ? S_BUSY : S_IDLE) :
                  (state_q == S_BUSY) ? ((count_q == LAST) ? S_DONE : S_BUSY) : S_IDLE;
    end

    // Operands are sampled every IDLE cycle; only the one that enters BUSY matters.
    always_comb begin
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        if (state_q == S_IDLE) begin
            count_d  = '0;
            mcand_d  = read_data1;
            mplier_d = alu_b;
            prod_d   = '0;
        end else if (state_q == S_BUSY) begin
            count_d  = count_q + 1'b1;
            prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    always_comb begin
        stall_int = (state_q == S_BUSY) || (state_q == S_IDLE && is_mul && !flush);
        mul_done  = state_q == S_DONE;
    end

    // The visible stall is forced low while reset is held; the pipeline
    // register path uses the ungated version so reset stays off the data path.
    assign stall = stall_int && ie_rst_n;
    assign res_d = mul_done ? prod_q : alu_res;
`else
    assign stall_int = 1'b0;
    assign stall     = 1'b0;
    assign res_d     = alu_res;
`endif

    assign ctrl_in = {uncondbranch_in, branch_in, mem_read_in, mem_write_in, mem_to_reg_in};
    assign bubble  = flush || stall_int;
    assign ctrl_d  = bubble ? '0 : ctrl_in;

    always_ff @(posedge ie_clk or negedge ie_rst_n) begin
        if (!ie_rst_n) begin
            ctrl_q       <= '0;
            zero_q       <= 1'b0;
            alu_result_q <= '0;
            read_data2_q <= '0;
            pc_out_q     <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            zero_q       <= res_d == '0;
            alu_result_q <= res_d;
            read_data2_q <= read_data2_in;
            pc_out_q     <= pc_tgt;
        end
    end

    assign {uncondbranch, branch, mem_read, mem_write, mem_to_reg} = ctrl_q;
    assign zero       = zero_q;
    assign alu_result = alu_result_q;
    assign read_data2 = read_data2_q;
    assign pc_out     = pc_out_q;

endmodule

// File: tb/tb_i_execute.sv
// tb_i_execute: directed self-checking bench for the i_execute stage.
module tb_i_execute;

    logic        ie_clk = 1'b0;
    logic        ie_rst_n = 1'b1;
    logic        flush = 1'b0;
    logic [63:0] pc_in = '0;
    logic [63:0] read_data1 = '0;
    logic [63:0] read_data2_in = '0;
    logic [63:0] sign_ext_imm = '0;
    logic [10:0] opcode = '0;
    logic [1:0]  alu_op = '0;
    logic        alu_src = 1'b0;
    logic        uncondbranch_in = 1'b0;
    logic        branch_in = 1'b0;
    logic        mem_read_in = 1'b0;
    logic        mem_write_in = 1'b0;
    logic        mem_to_reg_in = 1'b0;
    logic        stall;
    logic        uncondbranch, branch, mem_read, mem_write, mem_to_reg, zero;
    logic [63:0] alu_result, read_data2, pc_out;
    logic [4:0]  ctrl;

    int checks = 0;
    int failures = 0;

    localparam logic [10:0] ADD = 11'b10001011000;
    localparam logic [10:0] SUB = 11'b11001011000;
    localparam logic [10:0] AND = 11'b10001010000;
    localparam logic [10:0] ORR = 11'b10101010000;
    localparam logic [10:0] MUL = 11'b10011011000;
    localparam logic [10:0] LDU = 11'b11111000010;
    localparam logic [10:0] CBZ = 11'b10110100000;

    assign ctrl = {uncondbranch, branch, mem_read, mem_write, mem_to_reg};

    always #5 ie_clk = ~ie_clk;

    i_execute dut (
        .ie_clk          (ie_clk),
        .ie_rst_n        (ie_rst_n),
        .flush           (flush),
        .pc_in           (pc_in),
        .read_data1      (read_data1),
        .read_data2_in   (read_data2_in),
        .sign_ext_imm    (sign_ext_imm),
        .opcode          (opcode),
        .alu_op          (alu_op),
        .alu_src         (alu_src),
        .uncondbranch_in (uncondbranch_in),
        .branch_in       (branch_in),
        .mem_read_in     (mem_read_in),
        .mem_write_in    (mem_write_in),
        .mem_to_reg_in   (mem_to_reg_in),
        .stall           (stall),
        .uncondbranch    (uncondbranch),
        .branch          (branch),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_to_reg      (mem_to_reg),
        .zero            (zero),
        .alu_result      (alu_result),
        .read_data2      (read_data2),
        .pc_out          (pc_out)
    );

    task automatic drive(input logic [10:0] op, input logic [1:0] aop, input logic src,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] imm,
                         input logic [63:0] pc, input logic [4:0] c);
        opcode = op;
        alu_op = aop;
        alu_src = src;
        read_data1 = a;
        read_data2_in = b;
        sign_ext_imm = imm;
        pc_in = pc;
        {uncondbranch_in, branch_in, mem_read_in, mem_write_in, mem_to_reg_in} = c;
    endtask

    task automatic tick;
        @(posedge ie_clk);
        #1;
    endtask

    task automatic test_reset;
        #2 ie_rst_n = 1'b0;
        drive(ADD, 2'b10, 1'b0, 64'd5, 64'd7, 64'd1, 64'h40, 5'b11111);
        #1;
        checks++; if (alu_result !== 64'd0) begin failures++; $display("FAIL reset_result got=%0h exp=0", alu_result); end
        checks++; if (ctrl !== 5'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=00000", ctrl); end
        checks++; if ({zero, stall} !== 2'b00) begin failures++; $display("FAIL reset_zero_stall got=%b exp=00", {zero, stall}); end
        checks++; if ({pc_out, read_data2} !== 128'd0) begin failures++; $display("FAIL reset_pc_rd2 got=%0h/%0h exp=0/0", pc_out, read_data2); end
        tick;
        checks++; if (alu_result !== 64'd0) begin failures++; $display("FAIL reset_held_result got=%0h exp=0", alu_result); end
        #2 ie_rst_n = 1'b1;
        tick;
    endtask

    task automatic test_alu;
        drive(ADD, 2'b10, 1'b0, 64'd5, 64'd7, 64'd0, 64'd0, 5'b0);
        tick;
        checks++; if (alu_result !== 64'd12) begin failures++; $display("FAIL add_result got=%0h exp=c", alu_result); end
        checks++; if (zero !== 1'b0) begin failures++; $display("FAIL add_zero got=%b exp=0", zero); end
        drive(SUB, 2'b10, 1'b0, 64'd7, 64'd7, 64'd0, 64'd0, 5'b0);
        tick;
        checks++; if (alu_result !== 64'd0) begin failures++; $display("FAIL sub_result got=%0h exp=0", alu_result); end
        checks++; if (zero !== 1'b1) begin failures++; $display("FAIL sub_zero got=%b exp=1", zero); end
        drive(AND, 2'b10, 1'b0, 64'hF0F0, 64'h0FF0, 64'd0, 64'd0, 5'b0);
        tick;
        checks++; if (alu_result !== 64'h00F0) begin failures++; $display("FAIL and_result got=%0h exp=f0", alu_result); end
        drive(ORR, 2'b10, 1'b0, 64'hF000, 64'h000F, 64'd0, 64'd0, 5'b0);
        tick;
        checks++; if (alu_result !== 64'hF00F) begin failures++; $display("FAIL orr_result got=%0h exp=f00f", alu_result); end
        drive(ADD, 2'b10, 1'b1, 64'd10, 64'd100, 64'd3, 64'd0, 5'b0);
        tick;
        checks++; if (alu_result !== 64'd13) begin failures++; $display("FAIL add_imm_result got=%0h exp=d", alu_result); end
        drive(11'h7FF, 2'b10, 1'b0, 64'd9, 64'd9, 64'd0, 64'd0, 5'b0);
        tick;
        checks++; if ({alu_result, zero} !== {64'd0, 1'b1}) begin failures++; $display("FAIL unknown_op got=%0h/%b exp=0/1", alu_result, zero); end
        drive(SUB, 2'b11, 1'b0, 64'd2, 64'd3, 64'd0, 64'd0, 5'b0);
        tick;
        checks++; if (alu_result !== 64'd5) begin failures++; $display("FAIL rsvd_add got=%0h exp=5", alu_result); end
        drive(SUB, 2'b10, 1'b0, 64'd0, 64'd1, 64'd0, 64'd0, 5'b0);
        tick;
        checks++; if (alu_result !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL sub_wrap got=%0h exp=ffffffffffffffff", alu_result); end
        drive(ADD, 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 5'b0);
        tick;
        checks++; if ({alu_result, zero} !== {64'd0, 1'b1}) begin failures++; $display("FAIL add_wrap got=%0h/%b exp=0/1", alu_result, zero); end
    endtask

    task automatic test_ldur;
        drive(LDU, 2'b00, 1'b1, 64'h100, 64'hDEAD, 64'd8, 64'd0, 5'b00101);
        tick;
        checks++; if (alu_result !== 64'h108) begin failures++; $display("FAIL ldur_addr got=%0h exp=108", alu_result); end
        checks++; if (ctrl !== 5'b00101) begin failures++; $display("FAIL ldur_ctrl got=%b exp=00101", ctrl); end
        checks++; if (read_data2 !== 64'hDEAD) begin failures++; $display("FAIL ldur_rd2 got=%0h exp=dead", read_data2); end
    endtask

    task automatic test_cbz;
        drive(CBZ, 2'b01, 1'b0, 64'h55, 64'd0, -64'sd4, 64'h40, 5'b01000);
        tick;
        checks++; if ({zero, ctrl} !== 6'b101000) begin failures++; $display("FAIL cbz_taken got=%b/%b exp=1/01000", zero, ctrl); end
        checks++; if (pc_out !== 64'h30) begin failures++; $display("FAIL cbz_target got=%0h exp=30", pc_out); end
        drive(CBZ, 2'b01, 1'b0, 64'h55, 64'd3, -64'sd4, 64'h40, 5'b01000);
        tick;
        checks++; if ({alu_result, zero} !== {64'd3, 1'b0}) begin failures++; $display("FAIL cbz_not_taken got=%0h/%b exp=3/0", alu_result, zero); end
    endtask

    task automatic test_flush;
        drive(LDU, 2'b00, 1'b1, 64'h200, 64'h77, 64'd16, 64'd0, 5'b00010);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        checks++; if (ctrl !== 5'b0) begin failures++; $display("FAIL flush_stur_ctrl got=%b exp=00000", ctrl); end
        drive(LDU, 2'b00, 1'b1, 64'h200, 64'h77, 64'd16, 64'd0, 5'b00010);
        tick;
        checks++; if ({ctrl, alu_result} !== {5'b00010, 64'h210}) begin failures++; $display("FAIL stur_after_flush got=%b/%0h exp=00010/210", ctrl, alu_result); end
    endtask

    task automatic test_back_to_back;
        drive(ADD, 2'b00, 1'b1, 64'd0, 64'd0, 64'd3, 64'h1000, 5'b10000);
        tick;
        checks++; if ({ctrl, pc_out} !== {5'b10000, 64'h100C}) begin failures++; $display("FAIL b2b_b got=%b/%0h exp=10000/100c", ctrl, pc_out); end
        drive(ORR, 2'b10, 1'b0, 64'h1, 64'h2, 64'd0, 64'd0, 5'b00001);
        tick;
        checks++; if ({ctrl, alu_result} !== {5'b00001, 64'h3}) begin failures++; $display("FAIL b2b_orr got=%b/%0h exp=00001/3", ctrl, alu_result); end
        drive(CBZ, 2'b01, 1'b0, 64'h0, 64'h9, 64'd1, 64'h8, 5'b01000);
        tick;
        checks++; if ({ctrl, alu_result, pc_out} !== {5'b01000, 64'h9, 64'hC}) begin failures++; $display("FAIL b2b_cbz got=%b/%0h/%0h exp=01000/9/c", ctrl, alu_result, pc_out); end
    endtask

    task automatic test_async_reset;
        drive(ADD, 2'b10, 1'b0, 64'd1, 64'd1, 64'd0, 64'd0, 5'b11111);
        tick;
        checks++; if ({ctrl, alu_result} !== {5'b11111, 64'd2}) begin failures++; $display("FAIL pre_areset got=%b/%0h exp=11111/2", ctrl, alu_result); end
        #3 ie_rst_n = 1'b0;
        #1;
        checks++; if ({ctrl, alu_result} !== {5'b0, 64'd0}) begin failures++; $display("FAIL areset_immediate got=%b/%0h exp=00000/0", ctrl, alu_result); end
        #1 ie_rst_n = 1'b1;
        tick;
        checks++; if (alu_result !== 64'd2) begin failures++; $display("FAIL post_areset got=%0h exp=2", alu_result); end
    endtask

`ifdef IE_MUL_EN
    task automatic test_mul;
        int n;
        drive(MUL, 2'b10, 1'b0, 64'd6, 64'd7, 64'd0, 64'd0, 5'b00001);
        #1;
        n = 0;
        while (stall && n < 200) begin
            tick;
            n++;
        end
        checks++; if (n !== 65) begin failures++; $display("FAIL mul_stall_cycles got=%0d exp=65", n); end
        checks++; if (ctrl !== 5'b0) begin failures++; $display("FAIL mul_bubble got=%b exp=00000", ctrl); end
        tick;
        checks++; if ({ctrl, alu_result, zero} !== {5'b00001, 64'd42, 1'b0}) begin failures++; $display("FAIL mul_result got=%b/%0h/%b exp=00001/2a/0", ctrl, alu_result, zero); end
        drive(MUL, 2'b10, 1'b0, 64'd3, 64'd4, 64'd0, 64'd0, 5'b0);
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL mul2_stall got=%b exp=1", stall); end
        n = 0;
        while (stall && n < 200) begin
            tick;
            n++;
        end
        tick;
        checks++; if ({n, alu_result} !== {32'd65, 64'd12}) begin failures++; $display("FAIL mul2_result got=%0d/%0h exp=65/c", n, alu_result); end
        drive(MUL, 2'b10, 1'b0, 64'd5, 64'd5, 64'd0, 64'd0, 5'b0);
        #1;
        n = 0;
        while (stall && n < 200) begin
            tick;
            n++;
        end
        tick;
        checks++; if ({n, alu_result} !== {32'd65, 64'd25}) begin failures++; $display("FAIL mul3_b2b got=%0d/%0h exp=65/19", n, alu_result); end
    endtask

    task automatic test_mul_flush;
        drive(MUL, 2'b10, 1'b0, 64'd6, 64'd7, 64'd0, 64'd0, 5'b00001);
        repeat (11) tick;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL mul_busy_stall got=%b exp=1", stall); end
        flush = 1'b1;
        tick;
        flush = 1'b0;
        drive(ADD, 2'b10, 1'b0, 64'd1, 64'd2, 64'd0, 64'd0, 5'b00001);
        #1;
        checks++; if ({stall, ctrl} !== 6'b0) begin failures++; $display("FAIL mul_flush got=%b/%b exp=0/00000", stall, ctrl); end
        tick;
        checks++; if ({ctrl, alu_result} !== {5'b00001, 64'd3}) begin failures++; $display("FAIL mul_flush_next got=%b/%0h exp=00001/3", ctrl, alu_result); end
    endtask

    task automatic test_mul_reset;
        drive(MUL, 2'b10, 1'b0, 64'd6, 64'd7, 64'd0, 64'd0, 5'b0);
        repeat (5) tick;
        #2 ie_rst_n = 1'b0;
        #1;
        checks++; if ({stall, alu_result} !== {1'b0, 64'd0}) begin failures++; $display("FAIL mul_reset got=%b/%0h exp=0/0", stall, alu_result); end
        drive(ADD, 2'b10, 1'b0, 64'd4, 64'd4, 64'd0, 64'd0, 5'b0);
        #1 ie_rst_n = 1'b1;
        tick;
        checks++; if ({stall, alu_result} !== {1'b0, 64'd8}) begin failures++; $display("FAIL mul_reset_idle got=%b/%0h exp=0/8", stall, alu_result); end
    endtask
`else
    task automatic test_mul;
        drive(MUL, 2'b10, 1'b0, 64'd6, 64'd7, 64'd0, 64'd0, 5'b00001);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mul_nostall got=%b exp=0", stall); end
        tick;
        checks++; if ({alu_result, zero, ctrl} !== {64'd0, 1'b1, 5'b00001}) begin failures++; $display("FAIL mul_disabled got=%0h/%b/%b exp=0/1/00001", alu_result, zero, ctrl); end
    endtask
`endif

    initial begin
        test_reset;
        test_alu;
        test_ldur;
        test_cbz;
        test_flush;
        test_back_to_back;
        test_async_reset;
        test_mul;
`ifdef IE_MUL_EN
        test_mul_flush;
        test_mul_reset;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
